// File: rtl/polling_os_sequencer_if.sv
// rtl/polling_os_sequencer_if.sv - LTSSM/encoder signal bundle for the training ordered-set sequencer
//
// Ports (slave = sequencer side):
//   start, abort, tx_hold          : commands from the lane LTSSM
//   txdata[7:0], txdatak           : symbol and K-flag to the 8b/10b encoder
//   txelecidle                     : electrical idle request to the encoder
//   busy, done, os_count[15:0]     : sequence status back to the LTSSM
interface polling_os_sequencer_if;
    logic        start;
    logic        abort;
    logic        tx_hold;
    logic [7:0]  txdata;
    logic        txdatak;
    logic        txelecidle;
    logic        busy;
    logic        done;
    logic [15:0] os_count;

    modport master (
        output start, abort, tx_hold,
        input  txdata, txdatak, txelecidle, busy, done, os_count
    );

    modport slave (
        input  start, abort, tx_hold,
        output txdata, txdatak, txelecidle, busy, done, os_count
    );
endinterface

// File: rtl/polling_os_sequencer.sv
// rtl/polling_os_sequencer.sv - per-lane TS1/TS2 training ordered-set sequencer feeding the 8b/10b encoder
//
// Ports:
//   clk   : PHY parallel clock
//   reset : synchronous, active-high
//   bus   : polling_os_sequencer_if.slave (start/abort/tx_hold in; txdata/txdatak/
//           txelecidle/busy/done/os_count out, all registered)
// Parameters: NTS (TS1 count), NTS2 (TS2 count), N_FTS (TS symbol 3),
//             SKP_INTERVAL (only with OZ_SKP_INSERT_EN).
// Configuration macro: OZ_SKP_INSERT_EN enables periodic SKP ordered-set insertion.
module polling_os_sequencer #(
    parameter int         NTS   = 1024,
    parameter int         NTS2  = 16,
    parameter logic [7:0] N_FTS = 8'hFF
`ifdef OZ_SKP_INSERT_EN
    ,
    parameter int         SKP_INTERVAL = 1180
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    polling_os_sequencer_if.slave  bus
);
    localparam logic [7:0]  SYM_COM = 8'hBC;
    localparam logic [7:0]  SYM_PAD = 8'hF7;
    localparam logic [7:0]  TS1_ID  = 8'h4A;
    localparam logic [7:0]  TS2_ID  = 8'h45;
    // 32-bit copies so os_count compares never truncate large NTS/NTS2 values
    localparam logic [31:0] NTS_U   = NTS;
    localparam logic [31:0] NTS2_U  = NTS2;

`ifdef OZ_SKP_INSERT_EN
    localparam logic [7:0]  SYM_SKP = 8'h1C;
    localparam logic [31:0] SKP_U   = SKP_INTERVAL;
    typedef enum logic [2:0] {S_IDLE, S_TS1, S_TS2, S_SKP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_TS1, S_TS2, S_DONE} state_t;
`endif

    state_t      state, state_n;
    logic [3:0]  sym, sym_n;
    logic [15:0] os_count, os_count_n, os_inc;

    logic [7:0]  txdata_q, txdata_n;
    logic        txdatak_q, txdatak_n;
    logic        txelecidle_q, txelecidle_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

`ifdef OZ_SKP_INSERT_EN
    state_t      ret_state, ret_state_n;
    logic [11:0] skp_cnt, skp_cnt_n, skp_inc;
    logic        skp_due;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sym          <= 4'd0;
            os_count     <= 16'd0;
            txdata_q     <= 8'h00;
            txdatak_q    <= 1'b0;
            txelecidle_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef OZ_SKP_INSERT_EN
            ret_state    <= S_IDLE;
            skp_cnt      <= 12'd0;
`endif
        end else begin
            state        <= state_n;
            sym          <= sym_n;
            os_count     <= os_count_n;
            txdata_q     <= txdata_n;
            txdatak_q    <= txdatak_n;
            txelecidle_q <= txelecidle_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
`ifdef OZ_SKP_INSERT_EN
            ret_state    <= ret_state_n;
            skp_cnt      <= skp_cnt_n;
`endif
        end
    end

    // state/sym always name the symbol currently on the wire; the next-state
    // logic picks the following symbol and the output decode registers it.
    always_comb begin
        state_n    = state;
        sym_n      = sym;
        os_count_n = os_count;
        os_inc     = (os_count == 16'hFFFF) ? os_count : os_count + 16'd1;
`ifdef OZ_SKP_INSERT_EN
        ret_state_n = ret_state;
        skp_cnt_n   = skp_cnt;
        skp_inc     = (skp_cnt == 12'hFFF) ? skp_cnt : skp_cnt + 12'd1;
        // skp_inc includes the symbol being emitted this cycle
        skp_due     = ({20'd0, skp_inc} >= SKP_U);
`endif
        if (bus.abort) begin
            state_n    = S_IDLE;
            sym_n      = 4'd0;
            os_count_n = 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n    = S_TS1;
                        sym_n      = 4'd0;
                        os_count_n = 16'd0;
                    end
                end
                S_TS1, S_TS2: begin
                    if (!bus.tx_hold) begin
`ifdef OZ_SKP_INSERT_EN
                        skp_cnt_n = skp_inc;
`endif
                        if (sym == 4'd15) begin
                            sym_n      = 4'd0;
                            os_count_n = os_inc;
                            if (state == S_TS1 && {16'd0, os_inc} == NTS_U) begin
                                state_n    = S_TS2;
                                os_count_n = 16'd0;
                            end else if (state == S_TS2 && {16'd0, os_inc} == NTS2_U) begin
                                state_n = S_DONE;
                            end
`ifdef OZ_SKP_INSERT_EN
                            // SKP goes out first; the phase change resumes afterwards
                            if (skp_due) begin
                                ret_state_n = state_n;
                                state_n     = S_SKP;
                                skp_cnt_n   = 12'd0;
                            end
`endif
                        end else begin
                            sym_n = sym + 4'd1;
                        end
                    end
                end
`ifdef OZ_SKP_INSERT_EN
                S_SKP: begin
                    if (!bus.tx_hold) begin
                        if (sym == 4'd3) begin
                            state_n = ret_state;
                            sym_n   = 4'd0;
                        end else begin
                            sym_n = sym + 4'd1;
                        end
                    end
                end
`endif
                S_DONE: begin
`ifdef OZ_SKP_INSERT_EN
                    skp_cnt_n = skp_inc;
`endif
                    if (bus.start) begin
                        state_n    = S_TS1;
                        sym_n      = 4'd0;
                        os_count_n = 16'd0;
                    end
`ifdef OZ_SKP_INSERT_EN
                    else if (skp_due) begin
                        ret_state_n = S_DONE;
                        state_n     = S_SKP;
                        sym_n       = 4'd0;
                        skp_cnt_n   = 12'd0;
                    end
`endif
                end
                default: begin
                    state_n = S_IDLE;
                    sym_n   = 4'd0;
                end
            endcase
        end
    end

    // Output decode of the next symbol; a hold keeps state_n/sym_n unchanged
    // so the same symbol is simply re-registered.
    always_comb begin
        txdata_n     = 8'h00;
        txdatak_n    = 1'b0;
        txelecidle_n = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        case (state_n)
            S_TS1, S_TS2: begin
                busy_n = 1'b1;
                case (sym_n)
                    4'd0:       begin txdata_n = SYM_COM; txdatak_n = 1'b1; end
                    4'd1, 4'd2: begin txdata_n = SYM_PAD; txdatak_n = 1'b1; end
                    4'd3:       txdata_n = N_FTS;
                    4'd4:       txdata_n = 8'h02;
                    4'd5:       txdata_n = 8'h00;
                    default:    txdata_n = (state_n == S_TS1) ? TS1_ID : TS2_ID;
                endcase
            end
`ifdef OZ_SKP_INSERT_EN
            S_SKP: begin
                busy_n    = 1'b1;
                txdatak_n = 1'b1;
                txdata_n  = (sym_n == 4'd0) ? SYM_COM : SYM_SKP;
            end
`endif
            S_DONE:  done_n = 1'b1;
            default: txelecidle_n = 1'b1;
        endcase
    end

    assign bus.txdata     = txdata_q;
    assign bus.txdatak    = txdatak_q;
    assign bus.txelecidle = txelecidle_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.os_count   = os_count;
endmodule

// File: tb/tb_polling_os_sequencer.sv
// tb/tb_polling_os_sequencer.sv - scoreboard bench for polling_os_sequencer
module tb_polling_os_sequencer;
    localparam int NTS  = 4;
    localparam int NTS2 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic tx_hold = 1'b0;

    int checks = 0;
    int failures = 0;

    // expected entry: {os_count[15:0], k, data[7:0]}
    logic [24:0] exp_q[$];

    logic [7:0]  o_data;
    logic        o_k, o_ei, o_busy, o_done;
    logic [15:0] o_os;

    polling_os_sequencer_if bus();
    assign bus.start   = start;
    assign bus.abort   = abort;
    assign bus.tx_hold = tx_hold;

`ifdef OZ_SKP_INSERT_EN
    logic sel = 1'b0;
    polling_os_sequencer_if bus_s();
    assign bus_s.start   = start;
    assign bus_s.abort   = abort;
    assign bus_s.tx_hold = tx_hold;

    polling_os_sequencer #(.NTS(NTS), .NTS2(NTS2), .N_FTS(8'hFF), .SKP_INTERVAL(4000))
        dut (.clk(clk), .reset(reset), .bus(bus));
    polling_os_sequencer #(.NTS(NTS), .NTS2(NTS2), .N_FTS(8'hFF), .SKP_INTERVAL(40))
        dut_skp (.clk(clk), .reset(reset), .bus(bus_s));

    assign o_data = sel ? bus_s.txdata     : bus.txdata;
    assign o_k    = sel ? bus_s.txdatak    : bus.txdatak;
    assign o_ei   = sel ? bus_s.txelecidle : bus.txelecidle;
    assign o_busy = sel ? bus_s.busy       : bus.busy;
    assign o_done = sel ? bus_s.done       : bus.done;
    assign o_os   = sel ? bus_s.os_count   : bus.os_count;
`else
    polling_os_sequencer #(.NTS(NTS), .NTS2(NTS2), .N_FTS(8'hFF))
        dut (.clk(clk), .reset(reset), .bus(bus));

    assign o_data = bus.txdata;
    assign o_k    = bus.txdatak;
    assign o_ei   = bus.txelecidle;
    assign o_busy = bus.busy;
    assign o_done = bus.done;
    assign o_os   = bus.os_count;
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ts_sym(input bit ts2, input int idx);
        case (idx)
            0:       return {1'b1, 8'hBC};
            1, 2:    return {1'b1, 8'hF7};
            3:       return {1'b0, 8'hFF};
            4:       return {1'b0, 8'h02};
            5:       return {1'b0, 8'h00};
            default: return ts2 ? {1'b0, 8'h45} : {1'b0, 8'h4A};
        endcase
    endfunction

    task automatic push_ts(input bit ts2, input int n, input int os_base);
        for (int o = 0; o < n; o++)
            for (int s = 0; s < 16; s++)
                exp_q.push_back({16'(os_base + o), ts_sym(ts2, s)});
    endtask

    task automatic push_skp(input int os);
        exp_q.push_back({16'(os), 1'b1, 8'hBC});
        for (int s = 0; s < 3; s++) exp_q.push_back({16'(os), 1'b1, 8'h1C});
    endtask

    task automatic do_reset();
        start = 1'b0; abort = 1'b0; tx_hold = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Pops one expected symbol per cycle; hold/start are driven by sample index.
    task automatic drain(input string name, input int stop_at, input int hold_at,
                         input int hold_len, input int start_at);
        logic [24:0] e;
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < stop_at) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_os, o_k, o_data} !== e || o_ei !== 1'b0 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s[%0d] got os=%0d k=%b data=%h ei=%b busy=%b want os=%0d k=%b data=%h ei=0 busy=1",
                         name, i, o_os, o_k, o_data, o_ei, o_busy, e[24:9], e[8], e[7:0]);
            end
            tx_hold = (i >= hold_at && i < hold_at + hold_len);
            start   = (i == start_at);
            step();
            i++;
        end
        tx_hold = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_done(input string name);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ei !== 1'b0 || o_data !== 8'h00 || o_k !== 1'b0) begin
            failures++;
            $display("FAIL %s_done got done=%b busy=%b ei=%b k=%b data=%h want done=1 busy=0 ei=0 k=0 data=00",
                     name, o_done, o_busy, o_ei, o_k, o_data);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o_ei !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== 8'h00 ||
            o_k !== 1'b0 || o_os !== 16'd0) begin
            failures++;
            $display("FAIL %s got ei=%b busy=%b done=%b k=%b data=%h os=%0d want ei=1 busy=0 done=0 k=0 data=00 os=0",
                     name, o_ei, o_busy, o_done, o_k, o_data, o_os);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        check_idle("reset_state");
        reset = 1'b0;
        step();
        step();
        check_idle("idle_without_start");
    endtask

    task automatic test_sequence();
        do_reset();
        push_ts(1'b0, NTS, 0);
        push_ts(1'b1, NTS2, 0);
        pulse_start();
        drain("seq", 1000, -1, 0, -1);
        check_done("seq");
    endtask

    task automatic test_hold();
        do_reset();
        push_ts(1'b0, NTS, 0);
        push_ts(1'b1, NTS2, 0);
        for (int k = 0; k < 5; k++) exp_q.insert(7, exp_q[7]);
        pulse_start();
        drain("hold", 1000, 7, 5, -1);
        check_done("hold");
    endtask

    task automatic test_abort();
        do_reset();
        push_ts(1'b0, NTS, 0);
        push_ts(1'b1, NTS2, 0);
        pulse_start();
        drain("abort_pre", 80, -1, 0, -1);
        checks++;
        if (o_os !== 16'd1 || o_data !== 8'hBC) begin
            failures++;
            $display("FAIL abort_point got os=%0d data=%h want os=1 data=bc", o_os, o_data);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_idle");
        exp_q.delete();
        push_ts(1'b0, 1, 0);
        pulse_start();
        drain("abort_restart", 16, -1, 0, -1);
    endtask

    task automatic test_start_ignored();
        do_reset();
        push_ts(1'b0, NTS, 0);
        push_ts(1'b1, NTS2, 0);
        pulse_start();
        drain("start_busy", 1000, -1, 0, 20);
        check_done("start_busy");
        pulse_start();
        checks++;
        if (o_data !== 8'hBC || o_k !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0 ||
            o_ei !== 1'b0 || o_os !== 16'd0) begin
            failures++;
            $display("FAIL restart_from_done got data=%h k=%b busy=%b done=%b ei=%b os=%0d want data=bc k=1 busy=1 done=0 ei=0 os=0",
                     o_data, o_k, o_busy, o_done, o_ei, o_os);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_ts(1'b0, NTS, 0);
        pulse_start();
        drain("reset_mid_pre", 30, -1, 0, -1);
        reset = 1'b1;
        step();
        check_idle("reset_mid");
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) step();
        check_idle("reset_mid_stays_idle");
    endtask

`ifdef OZ_SKP_INSERT_EN
    task automatic test_skp();
        sel = 1'b1;
        do_reset();
        push_ts(1'b0, 3, 0);
        push_skp(3);
        push_ts(1'b0, 1, 3);
        push_ts(1'b1, NTS2, 0);
        push_skp(NTS2);
        pulse_start();
        drain("skp", 1000, -1, 0, -1);
        check_done("skp");
        sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_abort();
        test_start_ignored();
        test_reset_mid();
`ifdef OZ_SKP_INSERT_EN
        test_skp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/polling_os_sequencer.md
# polling_os_sequencer

Per-lane training ordered-set sequencer for the PHY transmit path. On command from the lane LTSSM in POLLING_ACTIVE_START_TS1, it drives the 8-bit symbol/K-flag pair into that lane's 8b/10b encoder:
- NTS TS1 ordered sets,
- then NTS2 TS2 ordered sets,
- then logical idle.

It owns the lane's txelecidle. One instance sits per lane, between the LTSSM and b8b10conv.

## Interface
- NTS, 1024: number of TS1 ordered sets to send.
- NTS2, 16: number of TS2 ordered sets to send.
- N_FTS, 8'hFF: value placed in symbol 3 of every TS.
- SKP_INTERVAL, 1180: transmitted-symbol threshold for SKP insertion (used only with the configuration macro).
- clk  in  1  PHY parallel clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- start  in  1  begin sequence; 1-cycle pulse from the LTSSM.
- abort  in  1  stop immediately and return to electrical idle.
- tx_hold  in  1  stall; the current symbol is repeated and nothing advances.
- txdata  out  8  symbol to the encoder.
- txdatak  out  1  K-flag for txdata.
- txelecidle  out  1  electrical idle request to the encoder.
- busy  out  1  in TS1, TS2 or SKP.
- done  out  1  sequence complete; sending logical idle.
- os_count  out  16  ordered sets completed in the current phase.

## Operation
- States: IDLE, TS1, TS2, SKP, DONE. Symbol index sym runs 0..15 (0..3 in SKP).
- TS symbol content by index:
  - 0: COM, 8'hBC, k=1.
  - 1 and 2: PAD, 8'hF7, k=1 (link and lane numbers).
  - 3: N_FTS, k=0.
  - 4: 8'h02, k=0 (rate ID).
  - 5: 8'h00, k=0 (training control).
  - 6..15: TS identifier, k=0. TS1 uses 8'h4A (D10.2); TS2 uses 8'h45 (D5.2).
- IDLE:
  - Outputs: txelecidle=1, txdata=0, txdatak=0, busy=0, done=0.
  - start moves to TS1 with sym=0 and os_count=0.
- TS1 and TS2:
  - Each non-held cycle emits symbol sym, then increments sym.
  - At sym=15: sym wraps to 0 and os_count increments.
  - When os_count reaches NTS (in TS1), go to TS2 and clear os_count.
  - When os_count reaches NTS2 (in TS2), go to DONE.
- DONE:
  - Outputs: txelecidle=0, txdata=8'h00, txdatak=0, done=1.
  - State is held until start or abort.
- start while busy is ignored. start in DONE restarts at TS1.
- abort has priority over start and tx_hold. Any state goes to IDLE on the next cycle, with counters cleared.
- tx_hold freezes state, sym, os_count and all outputs. It has no effect in IDLE or DONE.
- os_count saturates at 16'hFFFF. It can only reach that limit if NTS or NTS2 is at least 65535.

## Timing
- Reset values: txelecidle=1, txdata=0, txdatak=0, busy=0, done=0, os_count=0. State is IDLE.
- All outputs are registered.
- Cycle after start: first COM on txdata, txelecidle=0, busy=1.
- Transition timing is back-to-back with no bubbles:
  - The last TS1 symbol 15 is followed on the next cycle by TS2 COM.
  - The last TS2 symbol 15 is followed on the next cycle by DONE (done=1).
- Sequence length with no holds and no SKP: 16·(NTS+NTS2) cycles from the first COM to done.
- abort asserted in cycle n gives txelecidle=1 and busy=0 in cycle n+1.
- reset asserted mid-sequence has the same effect as abort, and also clears the SKP interval counter.

## Configuration
- Macro OZ_SKP_INSERT_EN.
- Defined:
  - A 12-bit interval counter counts every emitted symbol in TS1, TS2 and DONE.
  - When the counter is at least SKP_INTERVAL at an ordered-set boundary (after symbol 15, or any cycle in DONE), the block enters SKP.
  - SKP emits four symbols: COM (8'hBC, k=1), then three SKP symbols (8'h1C, k=1).
  - SKP then returns to the interrupted state with sym=0. The counter clears at SKP entry.
  - SKP ordered sets do not count in os_count.
  - If the TS1→TS2 or TS2→DONE transition coincides with SKP entry, SKP is sent first, then the new state.
- Undefined: the SKP state, the interval counter and SKP_INTERVAL are removed; the sequence has no SKP.

## Test plan
- NTS=4, NTS2=2; reset, then pulse start.
  - Expect 64 TS1 symbols: bytes 0..5 are BC/F7/F7/FF/02/00 with k=1,1,1,0,0,0, followed by ten 4A.
  - Then 32 TS2 symbols with 45 identifiers.
  - done=1 at cycle 97 after start.
- tx_hold for 5 cycles at TS1 sym=7: txdata is held at 4A for 5 extra cycles, and total latency to done grows by exactly 5.
- abort at TS2 os_count=1: next cycle txelecidle=1, busy=0, os_count=0. A new start restarts TS1 from COM.
- start pulsed during TS1 is ignored (os_count is not reset). start in DONE restarts at TS1.
- reset asserted mid-TS1 gives the reset values on the next edge. Deasserting it leaves the block in IDLE until start.
- With OZ_SKP_INSERT_EN, SKP_INTERVAL=40, NTS=4:
  - SKP (BC,1C,1C,1C, all k=1) appears after the 3rd TS1 (48 symbols sent).
  - The 4th TS1 follows it.
  - os_count is unaffected.
